id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the pipelined RV32 reduced-ISA core, sitting between the decode stage (register file read ports, immediate generator, control unit) and the execute stage. It captures the operands read from the register file and the decoded controls, applies write-back bypass for same-cycle register-file writes, and detects load-use hazards, inserting a bubble when one occurs. It also honours external stall and flush requests and keeps a saturating bubble counter.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the bubble counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  hold all EX registers (back-pressure from EX/MEM)
- flush  in  1  kill the instruction entering EX (branch/jump taken)
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  generated immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1  decoded controls
- id_alu_ctrl  in  4  ALU operation
- wb_reg_write  in  1  write-back write enable (same signal driving the register file)
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  registered fields
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  registered controls
- ex_alu_ctrl  out  4  registered ALU op
- hazard_stall  out  1  combinational; IF and IF/ID must hold when 1
- bubble_count  out  CNT_W  saturating count of load-use bubbles

## Operation
- Write-back bypass: bypass1 = wb_data if wb_reg_write && wb_rd != 0 && wb_rd == id_rs1, else id_rs1_data; same for rs2. Index 0 always yields 0 regardless of id_rsN_data.
- hazard_stall = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2) && !flush && !stall. Conservative: rs2 is compared even for instructions that do not use it.
- Per-edge priority (highest first):
  - flush: ex_valid <= 0, all ex controls <= 0; other fields don't care (hold).
  - stall: all fields hold; refresh — if ex_valid && wb_reg_write && wb_rd != 0 && wb_rd == ex_rs1, ex_rs1_data <= wb_data (same for rs2).
  - hazard_stall: bubble — ex_valid <= 0, controls <= 0, bubble_count increments unless at all-ones.
  - otherwise: capture — ex_valid <= id_valid; indices, pc, imm, alu_ctrl captured; rsN_data <= bypassN; controls <= id controls AND id_valid.
- Invariant: whenever ex_valid = 0, ex_reg_write, ex_mem_read, ex_mem_write are 0.
- bubble_count saturates at 2^CNT_W - 1; cleared only by reset.

## Timing
- Latency 1 cycle ID -> EX on capture.
- reset = 0 asynchronously clears every register: all ex_* outputs 0, ex_valid 0, bubble_count 0; hazard_stall therefore 0. Release takes effect on the next rising edge; the first edge after release performs a normal capture.
- Reset asserted mid-stall or mid-bubble: cleared immediately, no pending state retained.
- Load-use: load in EX at cycle N with a dependent instruction in ID -> hazard_stall = 1 in N, bubble in EX at N+1, dependent instruction captured at N+2 with the loaded value bypassed from WB if it writes back that cycle.
- flush and stall together: flush wins. stall and a hazard together: stall wins, no bubble, no count.
- A WB write to the same register in the capture cycle must be visible in ex_rsN_data at the next cycle (the register file returns the old value in that cycle).

## Test plan
- Reset: drive reset=0 mid-run with ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, id_pc=0x40, id_valid=1 -> ex_pc=0x40, ex_valid=1 one cycle later.
- Bypass: id_rs1=5, id_rs1_data=0x11, wb_reg_write=1, wb_rd=5, wb_data=0xABCD -> ex_rs1_data=0xABCD; same with wb_rd=0 and id_rs1=0 -> ex_rs1_data=0.
- Load-use: ex_mem_read=1, ex_rd=7; id_rs2=7 -> hazard_stall=1, next cycle ex_valid=0, ex_reg_write=0, bubble_count=1; with ex_rd=0 -> no hazard.
- Stall refresh: stall=1 for 3 cycles with ex_rs1=9, ex_valid=1; wb writes x9=0x55 in cycle 2 -> ex_rs1_data=0x55 from then on, all other fields unchanged.
- Flush priority: flush=1, stall=1, hazard conditions true -> ex_valid=0, controls 0, bubble_count unchanged, hazard_stall=0.
- Saturation: force 2^CNT_W+2 bubbles -> bubble_count stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// stall/flush handling and a saturating bubble counter.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic [3:0]       id_alu_ctrl,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_imm,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic [3:0]       ex_alu_ctrl,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_count
);
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic [3:0]      alu_ctrl;
   } ex_t;

   ex_t             ex_d, ex_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [XLEN-1:0] byp1, byp2;
   logic            wb_ok;

   assign wb_ok = wb_reg_write && wb_rd != 5'd0;
   // x0 reads as zero no matter what the register file returns
   assign byp1 = id_rs1 == 5'd0 ? '0 : (wb_ok && wb_rd == id_rs1) ? wb_data : id_rs1_data;
   assign byp2 = id_rs2 == 5'd0 ? '0 : (wb_ok && wb_rd == id_rs2) ? wb_data : id_rs2_data;

   assign hazard_stall = id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 &&
                         (ex_q.rd == id_rs1 || ex_q.rd == id_rs2) && !flush && !stall;

   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (flush || (!stall && hazard_stall)) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
         ex_d.mem_write = 1'b0;
         ex_d.alu_src   = 1'b0;
         if (!flush) cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end else if (stall) begin
         // held operands would otherwise miss a write-back landing while stalled
         if (ex_q.valid && wb_ok && wb_rd == ex_q.rs1) ex_d.rs1_data = wb_data;
         if (ex_q.valid && wb_ok && wb_rd == ex_q.rs2) ex_d.rs2_data = wb_data;
      end else begin
         ex_d.valid     = id_valid;
         ex_d.pc        = id_pc;
         ex_d.imm       = id_imm;
         ex_d.rs1_data  = byp1;
         ex_d.rs2_data  = byp2;
         ex_d.rs1       = id_rs1;
         ex_d.rs2       = id_rs2;
         ex_d.rd        = id_rd;
         ex_d.reg_write = id_reg_write && id_valid;
         ex_d.mem_read  = id_mem_read && id_valid;
         ex_d.mem_write = id_mem_write && id_valid;
         ex_d.alu_src   = id_alu_src && id_valid;
         ex_d.alu_ctrl  = id_alu_ctrl;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_pc        = ex_q.pc;
   assign ex_imm       = ex_q.imm;
   assign ex_rs1_data  = ex_q.rs1_data;
   assign ex_rs2_data  = ex_q.rs2_data;
   assign ex_rs1       = ex_q.rs1;
   assign ex_rs2       = ex_q.rs2;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign ex_alu_src   = ex_q.alu_src;
   assign ex_alu_ctrl  = ex_q.alu_ctrl;
   assign bubble_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage;
   logic        clk = 0, reset = 0, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, wb_reg_write;
   logic [3:0]  id_alu_ctrl;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, hazard_stall;
   logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_alu_ctrl;
   logic [15:0] bubble_count;
   logic        s_valid, s_rw, s_mr, s_mw, s_as, s_hz;
   logic [31:0] s_pc, s_imm, s_d1, s_d2;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic [3:0]  s_ac, s_cnt;
   int checks = 0, errors = 0;

   typedef struct {
      bit          full;
      logic        v;
      logic [31:0] pc, r1, r2;
      logic [4:0]  rd;
      logic        rw, mr;
      logic [15:0] bub;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl),
      .hazard_stall(hazard_stall), .bubble_count(bubble_count));

   id_ex_stage #(.XLEN(32), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_valid(s_valid), .ex_pc(s_pc), .ex_imm(s_imm), .ex_rs1_data(s_d1),
      .ex_rs2_data(s_d2), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_reg_write(s_rw),
      .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_alu_src(s_as), .ex_alu_ctrl(s_ac),
      .hazard_stall(s_hz), .bubble_count(s_cnt));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      {stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write, id_alu_src, wb_reg_write} = '0;
      {id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data} = '0;
      {id_rs1, id_rs2, id_rd, wb_rd} = '0;
      id_alu_ctrl = '0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                        input logic rw, input logic mr);
      id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_imm = pc + 32'h100; id_alu_ctrl = 4'h3;
   endtask

   task automatic push(input bit full, input logic v, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [15:0] bub);
      exp_t e;
      e.full = full; e.v = v; e.pc = pc; e.r1 = r1; e.r2 = r2; e.rd = rd; e.rw = rw; e.mr = mr; e.bub = bub;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("ex_valid", ex_valid, e.v);
      chk("ex_reg_write", ex_reg_write, e.rw);
      chk("ex_mem_read", ex_mem_read, e.mr);
      chk("bubble_count", bubble_count, e.bub);
      if (!ex_valid) chk("invariant_mem_write", ex_mem_write, 0);
      if (e.full) begin
         chk("ex_pc", ex_pc, e.pc);
         chk("ex_rs1_data", ex_rs1_data, e.r1);
         chk("ex_rs2_data", ex_rs2_data, e.r2);
         chk("ex_rd", ex_rd, e.rd);
      end
   endtask

   initial begin
      idle();
      #12;
      chk("rst_valid", ex_valid, 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_bub", bubble_count, 0);
      chk("rst_hazard", hazard_stall, 0);
      reset = 1;
      @(negedge clk);
      // bypass of rs1 from a same-cycle write-back
      instr(32'h40, 5, 32'h11, 6, 32'h22, 3, 1, 0);
      wb_reg_write = 1; wb_rd = 5; wb_data = 32'hABCD;
      push(1, 1, 32'h40, 32'hABCD, 32'h22, 3, 1, 0, 0);
      tick();
      chk("ex_alu_ctrl", ex_alu_ctrl, 4'h3);
      chk("ex_imm", ex_imm, 32'h140);
      // x0 reads zero even with a wb to x0 and nonzero RF data
      instr(32'h44, 0, 32'h99, 0, 32'h98, 4, 1, 0);
      wb_rd = 0; wb_data = 32'h1234;
      push(1, 1, 32'h44, 0, 0, 4, 1, 0, 0);
      tick();
      // invalid ID instruction carries no controls
      instr(32'h48, 1, 32'h1, 2, 32'h2, 3, 1, 1);
      id_valid = 0; wb_reg_write = 0;
      push(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      // load-use
      instr(32'h50, 1, 32'h1, 2, 32'h2, 7, 1, 1);
      push(1, 1, 32'h50, 32'h1, 32'h2, 7, 1, 1, 0);
      tick();
      instr(32'h54, 1, 32'h10, 7, 32'h70, 8, 1, 0);
      #1;
      chk("hazard_on", hazard_stall, 1);
      push(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("hazard_after_bubble", hazard_stall, 0);
      wb_reg_write = 1; wb_rd = 7; wb_data = 32'h77;
      push(1, 1, 32'h54, 32'h10, 32'h77, 8, 1, 0, 1);
      tick();
      // load to x0 never stalls
      wb_reg_write = 0;
      instr(32'h58, 1, 32'h1, 2, 32'h2, 0, 1, 1);
      push(1, 1, 32'h58, 32'h1, 32'h2, 0, 1, 1, 1);
      tick();
      instr(32'h5C, 0, 32'h0, 0, 32'h0, 5, 1, 0);
      #1;
      chk("hazard_rd0", hazard_stall, 0);
      push(1, 1, 32'h5C, 0, 0, 5, 1, 0, 1);
      tick();
      // stall with write-back refresh
      instr(32'h60, 9, 32'h1, 4, 32'h2, 10, 1, 0);
      push(1, 1, 32'h60, 32'h1, 32'h2, 10, 1, 0, 1);
      tick();
      stall = 1;
      instr(32'h99, 11, 32'hDEAD, 12, 32'hBEEF, 13, 0, 1);
      push(1, 1, 32'h60, 32'h1, 32'h2, 10, 1, 0, 1);
      tick();
      wb_reg_write = 1; wb_rd = 9; wb_data = 32'h55;
      push(1, 1, 32'h60, 32'h55, 32'h2, 10, 1, 0, 1);
      tick();
      wb_reg_write = 0;
      push(1, 1, 32'h60, 32'h55, 32'h2, 10, 1, 0, 1);
      tick();
      chk("stall_rs1", ex_rs1, 9);
      chk("stall_imm", ex_imm, 32'h160);
      // stall beats hazard, flush beats both
      stall = 0;
      instr(32'h70, 1, 32'h1, 2, 32'h2, 7, 1, 1);
      push(1, 1, 32'h70, 32'h1, 32'h2, 7, 1, 1, 1);
      tick();
      instr(32'h74, 7, 32'h3, 0, 32'h0, 8, 1, 0);
      stall = 1;
      #1;
      chk("hazard_stalled", hazard_stall, 0);
      push(1, 1, 32'h70, 32'h1, 32'h2, 7, 1, 1, 1);
      tick();
      flush = 1;
      #1;
      chk("hazard_flushed", hazard_stall, 0);
      push(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      // asynchronous reset mid-run with a valid instruction in EX
      idle();
      instr(32'h80, 1, 32'h1, 2, 32'h2, 3, 1, 0);
      push(1, 1, 32'h80, 32'h1, 32'h2, 3, 1, 0, 1);
      tick();
      #2 reset = 0;
      #1;
      chk("arst_valid", ex_valid, 0);
      chk("arst_pc", ex_pc, 0);
      chk("arst_rs1_data", ex_rs1_data, 0);
      chk("arst_reg_write", ex_reg_write, 0);
      chk("arst_bub", bubble_count, 0);
      #2 reset = 1;
      instr(32'h40, 0, 32'h0, 0, 32'h0, 1, 1, 0);
      push(1, 1, 32'h40, 0, 0, 1, 1, 0, 0);
      tick();
      // 2^4+2 bubbles on the 4-bit counter instance
      for (int i = 0; i < 18; i++) begin
         instr(32'h200, 0, 32'h0, 0, 32'h0, 7, 1, 1);
         tick();
         instr(32'h204, 7, 32'h0, 0, 32'h0, 8, 1, 0);
         #1;
         chk("sat_hazard", s_hz, 1);
         tick();
         if (i == 14) chk("sat_15", s_cnt, 4'hF);
         if (i == 13) chk("sat_14", s_cnt, 4'hE);
      end
      chk("sat_final", s_cnt, 4'hF);
      chk("cnt16_final", bubble_count, 16'd18);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
